fp_to_linear_seq: RTL and testbench
===================================

Name: fp_to_linear_seq

Overview:
- Sequential decoder: converts the compact floating-point triple (sign S, 3-bit exponent E, 4-bit significand F) back to a 12-bit two's-complement linear value D.
- Inverse direction of the team's linear-to-float converter. Sits downstream of it, on the consumer/playback side.
- Reconstruction uses an iterative shifter (one bit per cycle) plus a valid/ready handshake on both sides.

Parameters:
- DW, 12, output width in bits (two's complement).
- EW, 3, exponent width.
- FW, 4, significand width.
- Parameter constraint: FW + (2**EW − 1) ≤ DW − 1. Defaults give 11 ≤ 11.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  S/E/F valid.
- in_ready  output  1  block can accept a new triple.
- s  input  1  sign (1 = negative).
- e  input  EW  exponent.
- f  input  FW  significand.
- out_valid  output  1  d holds a completed result.
- out_ready  input  1  consumer accepts d.
- d  output  DW  linear two's-complement result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- One clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset (rst_n low, immediately, regardless of clock):
  - state = IDLE
  - d = 0, out_valid = 0, busy = 0
  - internal mag = 0, cnt = 0, sgn = 0
  - in_ready = 1 (derived from state).
- in_ready = (state == IDLE), combinational from state only.
- States:
  - IDLE:
    - On the edge with in_valid & in_ready: mag ← zero-extended f (DW−1 bits), cnt ← e, sgn ← s; go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT, cnt != 0: mag ← mag << 1, cnt ← cnt − 1; stay in SHIFT.
  - SHIFT, cnt == 0:
    - d ← sgn ? −mag : mag, computed at DW-bit width.
    - out_valid ← 1; go to DONE.
  - DONE:
    - Hold d and out_valid stable.
    - On the edge with out_ready high: out_valid ← 0, go to IDLE. d keeps its last value.
- Latency: out_valid rises E+1 clock edges after the accept edge (E=0 → 1 edge, E=7 → 8 edges).
- Throughput: at most one conversion per E+3 cycles. No overlap; new input is accepted only in IDLE.
- Arithmetic:
  - Maximum magnitude is 15<<7 = 1920, so the result never overflows DW.
  - Negation is exact two's complement.
  - s=1 with mag=0 yields 12'h000 (no negative zero).
- Inputs s/e/f are sampled only on the accept edge. Later changes are ignored.
- out_ready high while not in DONE has no effect.
- in_valid high while not IDLE is not accepted. The producer must hold its data.
- Reset mid-SHIFT or mid-DONE aborts the conversion. The result is discarded and out_valid drops immediately.
- Non-canonical inputs (e.g. F MSB = 0 with E > 0) are decoded literally as F<<E. No error is flagged.

Optional Feature:
- Macro: FP2LIN_MIDPOINT_EN.
- Defined:
  - In the SHIFT cnt==0 cycle, the magnitude becomes mag + (1 << (E−1)) when E > 0, before the sign is applied. E is held internally from the accept edge.
  - This reconstructs at the centre of the quantisation bucket.
  - Maximum is 1920 + 64 = 1984, still within DW.
  - Latency is unchanged.
- Undefined: truncating reconstruction (mag = F<<E exactly), as described above.

Test Plan:
- Reset: rst_n low mid-SHIFT → out_valid = 0, d = 12'h000, in_ready = 1 asynchronously. After release, a new accept works.
- s=0, e=3, f=4'b1011, out_ready=1 → out_valid high 4 edges after accept, d = 12'h058 (88), then IDLE, in_ready = 1.
- s=1, e=7, f=4'b1111 → d = 12'h880 (−1920) after 8 edges. s=1, e=0, f=0 → d = 12'h000 after 1 edge.
- Backpressure: out_ready low for 5 cycles after out_valid → d and out_valid stable, in_ready = 0. A simultaneous in_valid pulse is ignored. Releasing out_ready → IDLE next edge.
- Back-to-back: stream e=0..7, f=4'b1000, s alternating → each d = ±(8<<e). Latencies are 1..8 edges. No input is lost while in_valid is held.
- FP2LIN_MIDPOINT_EN defined: s=0, e=3, f=4'b1011 → d = 12'h05C (92). e=0, f=5 → d = 12'h005.

Source files
------------

// File: rtl/fp_to_linear_seq.sv
// Sequential float-triple to linear decoder with a one-bit-per-cycle shifter.
// FP2LIN_MIDPOINT_EN: add half an LSB of the bucket for mid-bucket reconstruction.
module fp_to_linear_seq #(
  parameter int DW = 12,
  parameter int EW = 3,
  parameter int FW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          s,
  input  logic [EW-1:0] e,
  input  logic [FW-1:0] f,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] d,
  output logic          busy
);

  localparam int MW = DW - 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [MW-1:0] mag_q, mag_d;
  logic [EW-1:0] cnt_q, cnt_d;
  logic          sgn_q, sgn_d;
  logic [DW-1:0] d_q, d_d;
  logic          ov_q, ov_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] res_mag;
`ifdef FP2LIN_MIDPOINT_EN
  logic [EW-1:0] exp_q, exp_d;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ov_q;
  assign d         = d_q;
  assign busy      = busy_q;

  always_comb begin
    res_mag = {1'b0, mag_q};
`ifdef FP2LIN_MIDPOINT_EN
    // Centre of the bucket: half of the dropped LSB weight.
    if (exp_q != '0) begin
      res_mag = res_mag + (DW'(1) << (exp_q - 1'b1));
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    d_d     = d_q;
    ov_d    = ov_q;
    busy_d  = busy_q;
`ifdef FP2LIN_MIDPOINT_EN
    exp_d   = exp_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mag_d   = MW'(f);
          cnt_d   = e;
          sgn_d   = s;
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef FP2LIN_MIDPOINT_EN
          exp_d   = e;
`endif
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          d_d     = sgn_q ? -res_mag : res_mag;
          ov_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mag_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      d_q     <= '0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FP2LIN_MIDPOINT_EN
      exp_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      d_q     <= d_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
`ifdef FP2LIN_MIDPOINT_EN
      exp_q   <= exp_d;
`endif
    end
  end

endmodule

// File: tb/tb_fp_to_linear_seq.sv
// Self-checking bench for fp_to_linear_seq: vector table, corner sequences,
// and random triples against an arithmetic reference model.
module tb_fp_to_linear_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        s = 1'b0;
  logic [2:0]  e = '0;
  logic [3:0]  f = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] d;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  fp_to_linear_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .e(e), .f(f),
    .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          s;
    logic [2:0]  e;
    logic [3:0]  f;
    logic [11:0] exp_d;
    int          hold;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // Value a sign/exponent/significand triple stands for, in plain integers.
  function automatic logic [11:0] model(bit sg, int ex, int fr);
    int m;
    m = fr * (1 << ex);
`ifdef FP2LIN_MIDPOINT_EN
    if (ex > 0) m = m + (1 << (ex - 1));
`endif
    if (sg) m = -m;
    return 12'(m);
  endfunction

  // Expects to start at posedge+1 in IDLE.
  task automatic run_conv(input bit s_i, input logic [2:0] e_i,
                          input logic [3:0] f_i, input logic [11:0] exp_d,
                          input int hold, input string nm);
    int n;
    s = s_i; e = e_i; f = f_i; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    s = ~s_i; e = 3'($urandom); f = 4'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(n == int'(e_i) + 1, {nm, " latency"}, n, int'(e_i) + 1);
    chk(d == exp_d, {nm, " d"}, d, exp_d);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      @(posedge clk); #1;
      chk(out_valid && d == exp_d && !in_ready && busy,
          {nm, " hold"}, {out_valid, in_ready, busy, 17'd0, d},
          {3'b101, 17'd0, exp_d});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk(!out_valid && in_ready && !busy, {nm, " release"},
        {out_valid, in_ready, busy}, 3'b010);
  endtask

  initial begin
    int n;
    logic [11:0] ex;
    bit sr;
    logic [2:0] er;
    logic [3:0] fr;

`ifdef FP2LIN_MIDPOINT_EN
    tbl[0] = '{0, 3'd3, 4'b1011, 12'h05C, 0};
    tbl[1] = '{1, 3'd7, 4'b1111, 12'h840, 0};
    tbl[2] = '{1, 3'd0, 4'b0000, 12'h000, 0};
    tbl[3] = '{0, 3'd0, 4'b0101, 12'h005, 1};
    tbl[4] = '{1, 3'd3, 4'b1011, 12'hFA4, 5};
    tbl[5] = '{0, 3'd7, 4'b1111, 12'h7C0, 2};
`else
    tbl[0] = '{0, 3'd3, 4'b1011, 12'h058, 0};
    tbl[1] = '{1, 3'd7, 4'b1111, 12'h880, 0};
    tbl[2] = '{1, 3'd0, 4'b0000, 12'h000, 0};
    tbl[3] = '{0, 3'd0, 4'b0101, 12'h005, 1};
    tbl[4] = '{1, 3'd3, 4'b1011, 12'hFA8, 5};
    tbl[5] = '{0, 3'd7, 4'b1111, 12'h780, 2};
`endif

    #3;
    chk(in_ready && !out_valid && d == 12'h000 && !busy, "reset state",
        {in_ready, out_valid, busy, 17'd0, d}, 32'h8000_0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i])
      run_conv(tbl[i].s, tbl[i].e, tbl[i].f, tbl[i].exp_d, tbl[i].hold,
               $sformatf("vec%0d", i));

    // Reset mid-SHIFT.
    s = 1'b1; e = 3'd7; f = 4'hF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk(busy && !in_ready, "shift busy", {busy, in_ready}, 2'b10);
    rst_n = 1'b0; #1;
    chk(!out_valid && d == 12'h000 && in_ready && !busy, "rst mid-shift",
        {out_valid, in_ready, busy, 17'd0, d}, 32'h4000_0000);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_conv(0, 3'd3, 4'b1011, model(0, 3, 11), 0, "post-rst");

    // Reset mid-DONE discards a nonzero result.
    s = 1'b0; e = 3'd2; f = 4'h9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk(out_valid && d == model(0, 2, 9), "pre-rst done",
        {out_valid, 19'd0, d}, {1'b1, 19'd0, model(0, 2, 9)});
    #2 rst_n = 1'b0; #1;
    chk(!out_valid && d == 12'h000 && in_ready, "rst mid-done",
        {out_valid, in_ready, 18'd0, d}, 32'h4000_0000);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back with in_valid held high throughout.
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sr = k[0];
      s = sr; e = 3'(k); f = 4'b1000;
      @(posedge clk); #1;
      s = ~sr; e = 3'(k + 3); f = 4'hF;
      n = 0;
      while (!out_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      ex = model(sr, k, 8);
      chk(n == k + 1, $sformatf("b2b%0d latency", k), n, k + 1);
      chk(d == ex, $sformatf("b2b%0d d", k), d, ex);
      @(posedge clk); #1;
      chk(in_ready && !out_valid, $sformatf("b2b%0d idle", k),
          {in_ready, out_valid}, 2'b10);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;

    for (int r = 0; r < 40; r++) begin
      sr = 1'($urandom);
      er = 3'($urandom);
      fr = 4'($urandom);
      run_conv(sr, er, fr, model(sr, int'(er), int'(fr)),
               $urandom_range(0, 3), $sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
